// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, constants and the write-request record used by the
// register write arbiter and its result queue.
package reg_write_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [REG_W-1:0]  wn;
      logic [DATA_W-1:0] wd;
   } wr_req_t;

   function automatic logic is_real_reg(input logic [REG_W-1:0] wn);
      return wn != ZERO_REG;
   endfunction

endpackage

// File: rtl/wr_fifo.sv
// Circular queue of pending long-latency register writes, exposing every
// entry's register number so the arbiter can flag pending reads.
module wr_fifo
   import reg_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              push,
   input  logic                              pop,
   input  wr_req_t                           push_data,
   output wr_req_t                           head,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic                              full,
   output logic                              empty,
   output logic [DEPTH-1:0]                  valid,
   output logic [DEPTH-1:0][REG_W-1:0]       entry_wn
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   wr_req_t [DEPTH-1:0] mem_q, mem_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: validity comes only from pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i]    = CW'(PW'(i) - rd_ptr_q) < count_q;
         entry_wn[i] = mem_q[i].wn;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = count_q == CW'(DEPTH);
   assign empty = count_q == '0;

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges pipeline writeback and queued long-latency results onto the single
// register file write port, with starvation-driven pipeline stall requests.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              WB_RegWrite,
   input  logic [REG_W-1:0]  WB_WN,
   input  logic [DATA_W-1:0] WB_WD,
   input  logic              LU_Valid,
   output logic              LU_Ready,
   input  logic [REG_W-1:0]  LU_WN,
   input  logic [DATA_W-1:0] LU_WD,
   input  logic [REG_W-1:0]  RN1,
   input  logic [REG_W-1:0]  RN2,
   output logic              RegWrite,
   output logic [REG_W-1:0]  WN,
   output logic [DATA_W-1:0] WD,
   output logic              Pend1,
   output logic              Pend2,
   output logic              Stall_Req
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = $clog2(STARVE_MAX+1);

   logic              wb_eff, lu_push, grant_head, drained;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   wr_req_t           fifo_head;
   logic [DEPTH-1:0]  fifo_valid;
   logic [DEPTH-1:0][REG_W-1:0] fifo_wn;

   logic              reg_write_q, reg_write_d;
   logic [REG_W-1:0]  wn_q, wn_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              stall_q, stall_d;

   wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (Clk),
      .reset     (Reset),
      .push      (lu_push),
      .pop       (grant_head),
      .push_data ('{wn: LU_WN, wd: LU_WD}),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .valid     (fifo_valid),
      .entry_wn  (fifo_wn)
   );

   // While stalling, the head always wins; a WB write arriving then is dropped.
   always_comb begin
      wb_eff      = WB_RegWrite && is_real_reg(WB_WN);
      lu_push     = LU_Valid && LU_Ready && is_real_reg(LU_WN);
      grant_head  = !fifo_empty && (stall_q || !wb_eff);
      reg_write_d = grant_head || wb_eff;
      wn_d        = wn_q;
      wd_d        = wd_q;
      if (grant_head) begin
         wn_d = fifo_head.wn;
         wd_d = fifo_head.wd;
      end else if (wb_eff) begin
         wn_d = WB_WN;
         wd_d = WB_WD;
      end

      starve_d = starve_q;
      if (fifo_empty || grant_head) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end

      drained = (fifo_empty && !lu_push) ||
                (fifo_count == CW'(1) && grant_head && !lu_push);
      stall_d = drained ? 1'b0 : (stall_q || starve_q == SW'(STARVE_MAX));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         reg_write_q <= 1'b0;
         wn_q        <= '0;
         wd_q        <= '0;
         starve_q    <= '0;
         stall_q     <= 1'b0;
      end else begin
         reg_write_q <= reg_write_d;
         wn_q        <= wn_d;
         wd_q        <= wd_d;
         starve_q    <= starve_d;
         stall_q     <= stall_d;
      end
   end

   always_comb begin
      Pend1 = reg_write_q && wn_q == RN1;
      Pend2 = reg_write_q && wn_q == RN2;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_valid[i] && fifo_wn[i] == RN1) Pend1 = 1'b1;
         if (fifo_valid[i] && fifo_wn[i] == RN2) Pend2 = 1'b1;
      end
      Pend1 = Pend1 && is_real_reg(RN1);
      Pend2 = Pend2 && is_real_reg(RN2);
   end

   assign LU_Ready  = !fifo_full;
   assign RegWrite  = reg_write_q;
   assign WN        = wn_q;
   assign WD        = wd_q;
   assign Stall_Req = stall_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: every expected register-file write is queued when the
// stimulus that causes it is driven, and matched when RegWrite appears.
module tb_reg_write_arbiter;

   localparam int STARVE_MAX = 8;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        WB_RegWrite;
   logic [4:0]  WB_WN;
   logic [31:0] WB_WD;
   logic        LU_Valid;
   logic        LU_Ready;
   logic [4:0]  LU_WN;
   logic [31:0] LU_WD;
   logic [4:0]  RN1, RN2;
   logic        RegWrite;
   logic [4:0]  WN;
   logic [31:0] WD;
   logic        Pend1, Pend2;
   logic        Stall_Req;

   int testsRun = 0;
   int testsFailed = 0;
   logic [36:0] expQ[$];

   reg_write_arbiter #(.DEPTH(4), .STARVE_MAX(STARVE_MAX)) dut (
      .Clk(Clk), .Reset(Reset),
      .WB_RegWrite(WB_RegWrite), .WB_WN(WB_WN), .WB_WD(WB_WD),
      .LU_Valid(LU_Valid), .LU_Ready(LU_Ready), .LU_WN(LU_WN), .LU_WD(LU_WD),
      .RN1(RN1), .RN2(RN2),
      .RegWrite(RegWrite), .WN(WN), .WD(WD),
      .Pend1(Pend1), .Pend2(Pend2), .Stall_Req(Stall_Req)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic wbv, input logic [4:0] wbn, input logic [31:0] wbd,
                                input logic luv, input logic [4:0] lun, input logic [31:0] lud);
      WB_RegWrite = wbv; WB_WN = wbn; WB_WD = wbd;
      LU_Valid = luv; LU_WN = lun; LU_WD = lud;
   endtask

   task automatic expectWrite(input logic [4:0] wn, input logic [31:0] wd);
      expQ.push_back({wn, wd});
   endtask

   // Every committed write must be the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (RegWrite === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_write_wn", {27'd0, WN}, 32'hFFFF_FFFF);
         end else begin
            logic [36:0] e;
            e = expQ.pop_front();
            checkOutput("write_wn", {27'd0, WN}, {27'd0, e[36:32]});
            checkOutput("write_wd", WD, e[31:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int cyc;
      Reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      RN1 = 5; RN2 = 0;
      step(); step();
      checkOutput("reset_regwrite", {31'd0, RegWrite}, 0);
      checkOutput("reset_wn", {27'd0, WN}, 0);
      checkOutput("reset_wd", WD, 0);
      checkOutput("reset_stall", {31'd0, Stall_Req}, 0);
      checkOutput("reset_lu_ready", {31'd0, LU_Ready}, 1);
      checkOutput("reset_pend1", {31'd0, Pend1}, 0);
      Reset = 1'b0;

      // Plain writeback write, visible one cycle later and pending meanwhile.
      applyStimulus(1, 5, 32'h1234, 0, 0, 0);
      expectWrite(5, 32'h1234);
      RN1 = 5; RN2 = 6;
      step();
      checkOutput("wb_regwrite", {31'd0, RegWrite}, 1);
      checkOutput("wb_pend1", {31'd0, Pend1}, 1);
      checkOutput("wb_pend2", {31'd0, Pend2}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      step();
      checkOutput("idle_regwrite", {31'd0, RegWrite}, 0);
      checkOutput("idle_wn_hold", {27'd0, WN}, 5);

      // Single long-latency result: enqueue, grant, commit.
      applyStimulus(0, 0, 0, 1, 7, 32'hDEAD);
      expectWrite(7, 32'hDEAD);
      RN1 = 7;
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("lu_not_yet", {31'd0, RegWrite}, 0);
      checkOutput("lu_queued_pend", {31'd0, Pend1}, 1);
      step();
      checkOutput("lu_commit", {31'd0, RegWrite}, 1);
      checkOutput("lu_commit_pend", {31'd0, Pend1}, 1);
      step();
      checkOutput("lu_done_pend", {31'd0, Pend1}, 0);

      // Starvation: WB every cycle while four LU results fill the queue.
      RN1 = 3; RN2 = 0;
      for (cyc = 0; cyc < 40 && !Stall_Req; cyc++) begin
         if (cyc < 4) begin
            checkOutput("starve_lu_ready", {31'd0, LU_Ready}, 1);
            applyStimulus(1, 5'(16 + cyc % 8), 32'hA000 + cyc, 1, 5'(cyc + 1), 32'hB000 + cyc + 1);
         end else begin
            applyStimulus(1, 5'(16 + cyc % 8), 32'hA000 + cyc, 0, 0, 0);
         end
         expectWrite(WB_WN, WB_WD);
         step();
         if (cyc == 3) begin
            checkOutput("starve_full", {31'd0, LU_Ready}, 0);
            checkOutput("starve_pend_q", {31'd0, Pend1}, 1);
         end
      end
      checkOutput("stall_raised", {31'd0, Stall_Req}, 1);
      checkOutput("stall_not_early", {31'd0, cyc >= STARVE_MAX + 1}, 1);
      checkOutput("stall_not_late", {31'd0, cyc <= STARVE_MAX + 3}, 1);
      // A WB write during stall is dropped; the queue drains in order.
      applyStimulus(1, 30, 32'hBAD0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) expectWrite(5'(i), 32'hB000 + i);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      step(); step(); step();
      checkOutput("stall_cleared", {31'd0, Stall_Req}, 0);
      checkOutput("drain_lu_ready", {31'd0, LU_Ready}, 1);
      step();
      checkOutput("drain_sb_empty", expQ.size(), 0);

      // WB to r0 does not block the queue; LU to r0 is accepted but not kept.
      applyStimulus(0, 0, 0, 1, 9, 32'h9999);
      expectWrite(9, 32'h9999);
      step();
      applyStimulus(1, 0, 32'h5555, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 1, 0, 32'h1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("r0_lu_no_write", {31'd0, RegWrite}, 0);
      step();
      checkOutput("r0_lu_no_write2", {31'd0, RegWrite}, 0);
      checkOutput("r0_wn_hold", {27'd0, WN}, 9);

      // Full queue granted while LU offers: no push, ready again next cycle.
      RN1 = 11;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 5'(24 + i), 32'hC000 + i, 1, 5'(12 + i), 32'hD000 + 12 + i);
         expectWrite(WB_WN, WB_WD);
         step();
      end
      checkOutput("full_lu_ready", {31'd0, LU_Ready}, 0);
      checkOutput("full_no_stall", {31'd0, Stall_Req}, 0);
      applyStimulus(0, 0, 0, 1, 11, 32'hEEEE);
      expectWrite(12, 32'hD000 + 12);
      step();
      checkOutput("full_pop_ready", {31'd0, LU_Ready}, 1);
      checkOutput("full_no_push_pend", {31'd0, Pend1}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 13; i <= 15; i++) expectWrite(5'(i), 32'hD000 + i);
      step(); step(); step(); step();
      checkOutput("full_sb_empty", expQ.size(), 0);

      // Reset while stalled with three queued entries.
      for (cyc = 0; cyc < 40 && !Stall_Req; cyc++) begin
         if (cyc < 3)
            applyStimulus(1, 5'(16 + cyc % 8), 32'hF000 + cyc, 1, 5'(20 + cyc), 32'h7000 + cyc);
         else
            applyStimulus(1, 5'(16 + cyc % 8), 32'hF000 + cyc, 0, 0, 0);
         expectWrite(WB_WN, WB_WD);
         step();
      end
      checkOutput("rst_pre_stall", {31'd0, Stall_Req}, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      Reset = 1'b1;
      step();
      checkOutput("rst_regwrite", {31'd0, RegWrite}, 0);
      checkOutput("rst_stall", {31'd0, Stall_Req}, 0);
      checkOutput("rst_lu_ready", {31'd0, LU_Ready}, 1);
      for (int r = 0; r < 32; r++) begin
         RN1 = 5'(r); RN2 = 5'(31 - r);
         #1;
         checkOutput("rst_pend1", {31'd0, Pend1}, 0);
         checkOutput("rst_pend2", {31'd0, Pend2}, 0);
      end
      Reset = 1'b0;
      step(); step();
      checkOutput("rst_no_residual", {31'd0, RegWrite}, 0);
      checkOutput("final_sb_empty", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: long-latency result queue entries (power of two, 2..8).
REQ-002 Parameter STARVE_MAX, default 8: consecutive starved cycles before Stall_Req asserts.
REQ-003 Clk  in  1  single clock, all state on posedge; one clock; reset is synchronous and active-high.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 WB_RegWrite  in  1  pipeline writeback stage requests a register write this cycle.
REQ-006 WB_WN  in  5  pipeline write register number.
REQ-007 WB_WD  in  32  pipeline write data.
REQ-008 LU_Valid  in  1  long-latency unit (divider/load miss) offers a result.
REQ-009 LU_Ready  out  1  arbiter can accept the LU result this cycle.
REQ-010 LU_WN  in  5  LU destination register number.
REQ-011 LU_WD  in  32  LU result data.
REQ-012 RN1, RN2  in  5 each  register numbers being read in decode, for pending checks.
REQ-013 RegWrite  out  1  register file write enable, registered.
REQ-014 WN  out  5  register file write number, registered.
REQ-015 WD  out  32  register file write data, registered.
REQ-016 Pend1, Pend2  out  1 each  RN1/RN2 has a write not yet committed to the register file.
REQ-017 Stall_Req  out  1  request to freeze the pipeline so queued LU writes drain, registered.

Function
REQ-018 A WB write is effective only when WB_RegWrite=1 and WB_WN!=0; otherwise the WB slot is free.
REQ-019 An LU handshake occurs when LU_Valid=1 and LU_Ready=1; entries with LU_WN=0 are accepted but not enqueued.
REQ-020 LU_Ready = (registered occupancy < DEPTH); a pop in the same cycle does not raise LU_Ready when full.
REQ-021 The queue is FIFO; the head pops only when granted; push and pop in one cycle both take effect and occupancy is unchanged.
REQ-022 Grant priority per cycle: queue head if Stall_Req=1, else effective WB write, else queue head, else idle.
REQ-023 The granted write appears on RegWrite/WN/WD at the next posedge (latency 1); RegWrite=0 on idle cycles, WN/WD hold their previous values.
REQ-024 An effective WB write while Stall_Req=1 is a protocol error; it is dropped and the queue head is written instead.
REQ-025 Starve counter: increments each cycle the queue is non-empty and the head is not granted; clears on head pop or empty queue; saturates at STARVE_MAX.
REQ-026 Stall_Req registers to 1 when the starve counter reaches STARVE_MAX and stays 1 until occupancy reaches 0.
REQ-027 PendN = (RNN!=0) and RNN matches any valid queue entry or (RegWrite=1 and WN=RNN); combinational.
REQ-028 The pipeline must use Pend1/Pend2 to prevent WAW/RAW on queued registers; the arbiter performs no ordering kill.
REQ-029 Queue pointers wrap modulo DEPTH; occupancy is DEPTH+1 states (0..DEPTH).

Reset
REQ-030 Reset=1 at posedge: occupancy 0, pointers 0, starve counter 0, Stall_Req 0, RegWrite 0, WN 0, WD 0.
REQ-031 Reset mid-operation discards all queued entries and any in-flight write; LU_Ready=1 on the first cycle after reset.

Structure
REQ-032 Shared package holds: register-number width 5, data width 32, zero-register constant 0, write-request struct {wn, wd}.
REQ-033 One sub-module, wr_fifo (parameterised DEPTH, push/pop/full/empty, parallel entry view for pending compare).

Verification
REQ-034 WB_RegWrite=1, WB_WN=5, WB_WD=0x1234 -> next cycle RegWrite=1, WN=5, WD=0x1234; Pend1=1 for RN1=5 that cycle.
REQ-035 Idle WB, LU push WN=7 WD=0xDEAD -> next cycle queue head granted; following cycle RegWrite=1, WN=7, WD=0xDEAD.
REQ-036 WB write every cycle, 4 LU pushes (WN 1..4) -> LU_Ready=0 after 4th; Stall_Req=1 after 8 starved cycles; WB held low -> writes 1,2,3,4 in order; Stall_Req=0 when empty.
REQ-037 WB_WN=0 with WB_RegWrite=1 and queue holding WN=9 -> queue head written (WN=9); LU push with LU_WN=0 -> occupancy unchanged.
REQ-038 Full queue, simultaneous grant and LU_Valid=1 -> no push that cycle, LU_Ready=1 next cycle.
REQ-039 Reset asserted with 3 queued entries and Stall_Req=1 -> next cycle RegWrite=0, Stall_Req=0, Pend1=Pend2=0 for all RN, LU_Ready=1.
